// File: rtl/dpram_clr_pkg.sv
// Shared constants and FSM state type for the clearable dual-port RAM.
package dpram_clr_pkg;

  localparam int POLICY_P1WINS = 0;
  localparam int POLICY_P2WINS = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/dpram_clr_if.sv
// Port bundle for both RAM ports plus the clear request/busy pair.
interface dpram_clr_if #(
  parameter int DW = 8,
  parameter int AW = 14
);
  logic          clr;
  logic          busy;
  logic          wr1;
  logic [AW-1:0] a1;
  logic [DW-1:0] di1;
  logic [DW-1:0] do1;
  logic          wr2;
  logic [AW-1:0] a2;
  logic [DW-1:0] di2;
  logic [DW-1:0] do2;
  logic          collide;

  modport master (
    output clr, wr1, a1, di1, wr2, a2, di2,
    input  busy, do1, do2, collide
  );

  modport slave (
    input  clr, wr1, a1, di1, wr2, a2, di2,
    output busy, do1, do2, collide
  );
endinterface

// File: rtl/dpram_core.sv
// Plain 2^AW x DW storage: two write ports, two registered read ports.
// Reads return the pre-write contents; callers handle bypass and collisions.
module dpram_core #(
  parameter int DW = 8,
  parameter int AW = 14
) (
  input  logic          clock,
  input  logic          we1,
  input  logic [AW-1:0] a1,
  input  logic [DW-1:0] d1,
  input  logic          we2,
  input  logic [AW-1:0] a2,
  input  logic [DW-1:0] d2,
  output logic [DW-1:0] q1,
  output logic [DW-1:0] q2
);

  logic [DW-1:0] mem [2**AW];

  // Array writes and registered reads for both ports.
  always_ff @(posedge clock) begin
    if (we1) mem[a1] <= d1;
    if (we2) mem[a2] <= d2;
    q1 <= mem[a1];
    q2 <= mem[a2];
  end

endmodule

// File: rtl/dpram_clr.sv
// Dual-port RAM with clear engine, write-through, cross-port bypass,
// same-address collision resolution and an optional output stage.
module dpram_clr
  import dpram_clr_pkg::*;
#(
  parameter int            DW             = 8,
  parameter int            AW             = 14,
  parameter int            OUT_REG        = 0,
  parameter int            CLEAR_ON_RESET = 1,
  parameter logic [DW-1:0] CLEAR_VALUE    = '0,
  parameter int            POLICY         = 0
) (
  input logic        clock,
  input logic        reset,
  dpram_clr_if.slave bus
);

  localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};

  state_t        state;
  logic [AW-1:0] cnt;
  logic          busy_q;

  logic          run, same_addr, wen1, wen2, both;
  logic          c_we1, c_we2;
  logic [AW-1:0] c_a1;
  logic [DW-1:0] c_d1, q1, q2;

  logic          run_s1, fwd1_s1, fwd2_s1, col_s1;
  logic [DW-1:0] w1_s1, w2_s1, s1_do1, s1_do2;

  assign run       = (state == ST_RUN);
  assign same_addr = (bus.a1 == bus.a2);
  assign wen1      = run & ~bus.wr1;
  assign wen2      = run & ~bus.wr2;
  assign both      = wen1 & wen2 & same_addr;

  // The clear engine borrows port 1; the losing port's write is dropped.
  assign c_we1 = ~run | (wen1 & ~(both & (POLICY == POLICY_P2WINS)));
  assign c_a1  = run ? bus.a1  : cnt;
  assign c_d1  = run ? bus.di1 : CLEAR_VALUE;
  assign c_we2 = wen2 & ~(both & (POLICY == POLICY_P1WINS));

  dpram_core #(.DW(DW), .AW(AW)) u_core (
    .clock (clock),
    .we1   (c_we1),
    .a1    (c_a1),
    .d1    (c_d1),
    .we2   (c_we2),
    .a2    (bus.a2),
    .d2    (bus.di2),
    .q1    (q1),
    .q2    (q2)
  );

  // Clear/run FSM; the counter holds at the last address on exit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      busy_q <= (CLEAR_ON_RESET != 0);
      cnt    <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (cnt == CNT_LAST) begin
            state  <= ST_RUN;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.clr) begin
            state  <= ST_CLEAR;
            busy_q <= 1'b1;
            cnt    <= '0;
          end
        end
        default: begin
          state  <= ST_RUN;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Capture write-through / bypass words and the collision flag alongside the array read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_s1  <= 1'b0;
      fwd1_s1 <= 1'b0;
      fwd2_s1 <= 1'b0;
      col_s1  <= 1'b0;
      w1_s1   <= '0;
      w2_s1   <= '0;
    end else begin
      run_s1  <= run;
      fwd1_s1 <= wen1 | (wen2 & same_addr);
      fwd2_s1 <= wen2 | (wen1 & same_addr);
      col_s1  <= both;
      w1_s1   <= wen1 ? bus.di1 : bus.di2;
      w2_s1   <= wen2 ? bus.di2 : bus.di1;
    end
  end

  // Outputs read as zero for any cycle whose access was made while clearing.
  assign s1_do1 = run_s1 ? (fwd1_s1 ? w1_s1 : q1) : '0;
  assign s1_do2 = run_s1 ? (fwd2_s1 ? w2_s1 : q2) : '0;

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DW-1:0] do1_r, do2_r;
      logic          col_r;

      // Extra output stage, one cycle behind stage 1.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          do1_r <= '0;
          do2_r <= '0;
          col_r <= 1'b0;
        end else begin
          do1_r <= s1_do1;
          do2_r <= s1_do2;
          col_r <= col_s1;
        end
      end

      assign bus.do1     = do1_r;
      assign bus.do2     = do2_r;
      assign bus.collide = col_r;
    end else begin : g_noreg
      assign bus.do1     = s1_do1;
      assign bus.do2     = s1_do2;
      assign bus.collide = col_s1;
    end
  endgenerate

  assign bus.busy = busy_q;

endmodule

// File: doc/dpram_clr.md
Name: dpram_clr

Overview:
- Parametrised single-clock true dual-port RAM.
- Replaces fixed 16K x 8 video/CPU shared memory blocks.
- Two independent read/write ports with write-through on each port.
- Adds:
  - deterministic same-address collision resolution with a collision flag
  - optional output pipeline register
  - hardware clear engine that fills the array after reset or on request.

Parameters:
- DW, 8, data width in bits.
- AW, 14, address width; depth = 2^AW words.
- OUT_REG, 0, 1 adds one output register stage (read latency 2 instead of 1).
- CLEAR_ON_RESET, 1, 1 runs the clear engine when reset releases.
- CLEAR_VALUE, 0, DW-bit word written by the clear engine.
- POLICY, 0, write-collision winner: 0 = port 1 wins, 1 = port 2 wins.

Ports:
- clock  in  1  single clock for both ports.
- reset  in  1  asynchronous, active-low reset.
- clr  in  1  clear request pulse; sampled in RUN only.
- busy  out  1  high while the clear engine owns the array.
- wr1  in  1  port 1 write strobe, active-low.
- a1  in  AW  port 1 address.
- di1  in  DW  port 1 write data.
- do1  out  DW  port 1 read data.
- wr2  in  1  port 2 write strobe, active-low.
- a2  in  AW  port 2 address.
- di2  in  DW  port 2 write data.
- do2  out  DW  port 2 read data.
- collide  out  1  same-address write collision flag, aligned with do1/do2.

Behaviour:
- Reset (reset low, asynchronous):
  - do1, do2, collide and all pipeline stages go to 0.
  - Clear counter goes to 0.
  - State = CLEAR if CLEAR_ON_RESET=1, else RUN.
  - busy = 1 in CLEAR, 0 in RUN.
  - Array contents are not reset.
- FSM, two states:
  - CLEAR:
    - Each cycle writes CLEAR_VALUE at the counter address, then the counter increments.
    - When counter = 2^AW-1, that final write occurs and the next state is RUN.
    - Total clear time is exactly 2^AW cycles; busy falls on the first RUN cycle.
    - wr1/wr2 are ignored; do1/do2 and collide are forced to 0; clr is ignored.
  - RUN:
    - clr = 1 at a rising edge sets state = CLEAR and counter = 0; busy rises next cycle.
    - A port access presented in that same cycle still completes normally.
- Reset asserted mid-clear: restart from counter 0 (if CLEAR_ON_RESET=1).
- Port read, wrN=1:
  - doN = mem[aN], registered at the edge.
  - Latency 1 cycle, or 2 if OUT_REG=1.
- Port write, wrN=0:
  - mem[aN] <= diN.
  - doN = diN (write-through), same latency as a read.
- Cross-port read while the other port writes the same address in the same cycle:
  - The reader returns the newly written data (bypass).
  - No collide flag.
- Both ports write the same address in the same cycle:
  - The winner per POLICY is stored.
  - Each port's doN still shows its own diN.
  - collide = 1 for one cycle, aligned to the data latency.
- Both ports write different addresses: both stored, collide = 0.
- Both ports read the same address: both return the same data.
- collide only asserts in RUN.
- Address arithmetic is AW bits; the clear counter wraps to 0 only on re-entry to CLEAR.

Decomposition:
- Shared package: POLICY_P1WINS=0 and POLICY_P2WINS=1 constants, and an FSM state typedef {ST_CLEAR, ST_RUN}.
- One sub-module, dpram_core:
  - 2^AW x DW storage array with two synchronous write ports and two registered read ports.
  - Contains no collision or clear logic.
- Top level holds:
  - FSM and clear counter
  - port muxing (the clear engine drives port 1 during CLEAR)
  - bypass/collision compare logic
  - optional OUT_REG stage.

Test Plan:
- Clear after reset:
  - Stimulus: AW=4, CLEAR_VALUE=8'hA5, release reset.
  - busy high exactly 16 cycles.
  - Then reading addresses 0..15 returns 8'hA5 on both ports.
- Write-through latency:
  - Stimulus: OUT_REG=0, wr1=0, a1=3, di1=8'h3C.
  - do1 = 8'h3C one cycle later.
  - Read of a2=3 the following cycle returns 8'h3C.
  - With OUT_REG=1, both appear one cycle later.
- Collision:
  - Stimulus: POLICY=1, both ports write a=7, di1=8'h11, di2=8'h22.
  - collide pulses one cycle; do1=8'h11, do2=8'h22.
  - A later read of 7 returns 8'h22.
  - Repeat with POLICY=0: read returns 8'h11.
- Cross-port bypass:
  - Stimulus: wr1=0, a1=9, di1=8'h5A while port 2 reads a2=9.
  - do2 = 8'h5A; collide = 0.
- Clear request mid-traffic:
  - Stimulus: pulse clr in RUN while writing.
  - busy rises next cycle; writes during busy are ignored.
  - After 16 cycles all locations read CLEAR_VALUE.
- Reset mid-clear:
  - Stimulus: assert reset at counter=6.
  - do outputs go to 0 immediately.
  - After release, busy lasts a full 16 cycles.
